// File: rtl/timer_controller.sv
// Timer controller: turns button requests into increment/load/clear pulses
// for an external 8-bit program counter. The counter's value comes back on
// pc_value and is compared against target.
// Optional feature macro: TIMER_AUTO_RELOAD_EN. When it is defined, DONE
// waits one tick period, reloads preset and returns to RUN.
module timer_controller #(
  parameter int CLK_DIV_FAST = 4,
  parameter int CLK_DIV_SLOW = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  input  logic       load_btn,
  input  logic       mode,
  input  logic [7:0] preset,
  input  logic [7:0] target,
  input  logic [7:0] pc_value,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [7:0] pc_load_val,
  output logic       pc_reset,
  output logic [7:0] pc_reset_val,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

  localparam int DMAX = (CLK_DIV_SLOW > CLK_DIV_FAST) ? CLK_DIV_SLOW : CLK_DIV_FAST;
  localparam int PW   = $clog2(DMAX);

  state_t          st, st_n;
  logic [PW-1:0]   pre, pre_n;
  logic [PW-1:0]   div_m1;
  logic [3:0]      hist;
  logic [3:0]      btn, req;
  logic            arm;
  logic            mode_q;
  logic            inc_n, load_n, rst_n, done_n;
  logic [7:0]      lval_n;
  logic            req_start, req_stop, req_clr, req_load;
  logic            hit;

  assign pc_reset_val = 8'h00;
  assign state        = st;

  // {load, clear, stop, start}; arm masks the first cycle after reset so a
  // button held through reset is absorbed into the history, not seen as an edge
  assign btn       = {load_btn, clear_btn, stop_btn, start_btn};
  assign req       = btn & ~hist & {4{arm}};
  assign req_start = req[0];
  assign req_stop  = req[1];
  assign req_clr   = req[2];
  assign req_load  = req[3];

  assign div_m1 = mode ? PW'(CLK_DIV_SLOW - 1) : PW'(CLK_DIV_FAST - 1);

  // The cycle after an auto-reload pc_value still shows the old count, so
  // the terminal compare is skipped while pc_load is high
  assign hit = (pc_value == target) && !pc_load;

  // State, prescaler, button history and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      pre         <= '0;
      hist        <= '0;
      arm         <= 1'b0;
      mode_q      <= 1'b0;
      pc_inc      <= 1'b0;
      pc_load     <= 1'b0;
      pc_load_val <= 8'h00;
      pc_reset    <= 1'b1;
      done        <= 1'b0;
    end else begin
      st          <= st_n;
      pre         <= pre_n;
      hist        <= btn;
      arm         <= 1'b1;
      mode_q      <= mode;
      pc_inc      <= inc_n;
      pc_load     <= load_n;
      pc_load_val <= lval_n;
      pc_reset    <= rst_n;
      done        <= done_n;
    end
  end

  // Next state and next outputs; clear overrides everything, then each state
  // honours only the requests that mean something in it
  always_comb begin
    st_n   = st;
    pre_n  = pre;
    inc_n  = 1'b0;
    load_n = 1'b0;
    rst_n  = 1'b0;
    done_n = done;
    lval_n = pc_load_val;
    if (req_clr) begin
      st_n   = IDLE;
      pre_n  = '0;
      rst_n  = 1'b1;
      done_n = 1'b0;
    end else begin
      case (st)
        IDLE, PAUSE: begin
          if (req_load) begin
            load_n = 1'b1;
            lval_n = preset;
          end else if (req_start) begin
            st_n  = RUN;
            pre_n = '0;
          end
        end
        RUN: begin
          if (hit) begin
            st_n   = DONE;
            done_n = 1'b1;
            pre_n  = '0;
          end else if (req_stop) begin
            st_n = PAUSE;
          end else if (mode != mode_q) begin
            pre_n = '0;
          end else if (pre >= div_m1) begin
            pre_n = '0;
            inc_n = 1'b1;
          end else begin
            pre_n = pre + 1'b1;
          end
        end
        DONE: begin
`ifdef TIMER_AUTO_RELOAD_EN
          if (pre >= div_m1) begin
            pre_n  = '0;
            load_n = 1'b1;
            lval_n = preset;
            done_n = 1'b0;
            st_n   = RUN;
          end else begin
            pre_n = pre + 1'b1;
          end
`endif
        end
        default: st_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller: vector table plus hand-written multi-cycle
// sequences; expected outputs are queued before each edge and popped after.
module tb_timer_controller;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_DONE = 2'b11;

  typedef struct {
    logic [1:0] st;
    logic       dn;
    logic       inc;
    logic       ld;
    logic [7:0] lv;
    logic       rs;
  } exp_t;

  typedef struct {
    logic       s, p, c, l;
    logic [7:0] pre;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start_btn, stop_btn, clear_btn, load_btn, mode;
  logic [7:0] preset, target, pcv;
  logic       pc_inc, pc_load, pc_reset, done;
  logic [7:0] pc_load_val, pc_reset_val;
  logic [1:0] state;

  exp_t  sb[$];
  vec_t  tbl[$];
  int    nvec = 0;
  int    nbad = 0;
  string tag;
  logic [7:0] elv;

  timer_controller #(.CLK_DIV_FAST(4), .CLK_DIV_SLOW(8)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .load_btn(load_btn), .mode(mode), .preset(preset),
    .target(target), .pc_value(pcv), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .pc_reset(pc_reset), .pc_reset_val(pc_reset_val),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // program counter model fed back to the DUT
  always @(posedge clk) begin
    if (pc_reset)     pcv <= 8'h00;
    else if (pc_load) pcv <= pc_load_val;
    else if (pc_inc)  pcv <= pcv + 8'h01;
  end

  // the three pulses may never overlap
  always @(negedge clk) begin
    if ((int'(pc_inc) + int'(pc_load) + int'(pc_reset)) > 1) begin
      nbad++;
      $display("FAIL excl: inc=%0d load=%0d reset=%0d, at most one required", pc_inc, pc_load, pc_reset);
    end
  end

  function automatic exp_t mk(input logic [1:0] st, input logic dn, input logic inc,
                              input logic ld, input logic [7:0] lv, input logic rs);
    exp_t e;
    e.st = st; e.dn = dn; e.inc = inc; e.ld = ld; e.lv = lv; e.rs = rs;
    return e;
  endfunction

  task automatic addv(input logic s, input logic p, input logic c, input logic l,
                      input logic [7:0] pre, input exp_t e);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.l = l; v.pre = pre; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one clock: queue expectation, clock, pop and compare
  task automatic cyc(input exp_t e);
    exp_t g;
    sb.push_back(e);
    tick();
    g = sb.pop_front();
    nvec++;
    if (state !== g.st || done !== g.dn || pc_inc !== g.inc || pc_load !== g.ld ||
        pc_load_val !== g.lv || pc_reset !== g.rs || pc_reset_val !== 8'h00) begin
      nbad++;
      $display("FAIL %s: got st=%0d dn=%0d inc=%0d ld=%0d lv=%h rs=%0d rv=%h, want st=%0d dn=%0d inc=%0d ld=%0d lv=%h rs=%0d rv=00",
               tag, state, done, pc_inc, pc_load, pc_load_val, pc_reset, pc_reset_val,
               g.st, g.dn, g.inc, g.ld, g.lv, g.rs);
    end
  endtask

  task automatic do_clear();
    clear_btn = 1'b1;
    cyc(mk(S_IDLE, 0, 0, 0, elv, 1));
    clear_btn = 1'b0;
    cyc(mk(S_IDLE, 0, 0, 0, elv, 0));
  endtask

  // start with the counter three increments short of target
  task automatic run_to_done();
    int last;
    start_btn = 1'b1;
    cyc(mk(S_RUN, 0, 0, 0, elv, 0));
    start_btn = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    last = 24;
`else
    last = 20;
`endif
    for (int c = 2; c <= last; c++) begin
      if (c < 15)
        cyc(mk(S_RUN, 0, logic'(c == 5 || c == 9 || c == 13), 0, elv, 0));
`ifdef TIMER_AUTO_RELOAD_EN
      else if (c < 19)
        cyc(mk(S_DONE, 1, 0, 0, elv, 0));
      else if (c == 19) begin
        elv = preset;
        cyc(mk(S_RUN, 0, 0, 1, elv, 0));
      end else
        cyc(mk(S_RUN, 0, logic'(c == 23), 0, elv, 0));
`else
      else
        cyc(mk(S_DONE, 1, 0, 0, elv, 0));
`endif
    end
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b1; stop_btn = 1'b0; clear_btn = 1'b0; load_btn = 1'b0;
    mode = 1'b0; preset = 8'h00; target = 8'h50; elv = 8'h00;

    // reset with start held throughout
    tag = "reset";
    tick();
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 1));
    reset = 1'b0;
    tag = "rst_release";
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0));
    tag = "held_start";
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0));
    start_btn = 1'b0;
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0));

    // single-cycle vectors: start, stop, clear, load, preset -> outputs
    addv(0, 0, 0, 1, 8'h22, mk(S_IDLE,  0, 0, 1, 8'h22, 0));
    addv(0, 0, 0, 0, 8'h33, mk(S_IDLE,  0, 0, 0, 8'h22, 0));
    addv(0, 1, 0, 1, 8'h44, mk(S_IDLE,  0, 0, 1, 8'h44, 0));
    addv(0, 0, 0, 0, 8'h44, mk(S_IDLE,  0, 0, 0, 8'h44, 0));
    addv(0, 0, 1, 1, 8'h55, mk(S_IDLE,  0, 0, 0, 8'h44, 1));
    addv(0, 0, 0, 0, 8'h55, mk(S_IDLE,  0, 0, 0, 8'h44, 0));
    addv(1, 0, 0, 0, 8'h55, mk(S_RUN,   0, 0, 0, 8'h44, 0));
    addv(0, 0, 0, 0, 8'h55, mk(S_RUN,   0, 0, 0, 8'h44, 0));
    addv(0, 0, 0, 1, 8'h66, mk(S_RUN,   0, 0, 0, 8'h44, 0));
    addv(0, 0, 0, 0, 8'h66, mk(S_RUN,   0, 0, 0, 8'h44, 0));
    addv(0, 0, 0, 0, 8'h66, mk(S_RUN,   0, 1, 0, 8'h44, 0));
    addv(0, 1, 0, 0, 8'h66, mk(S_PAUSE, 0, 0, 0, 8'h44, 0));
    addv(0, 0, 0, 0, 8'h66, mk(S_PAUSE, 0, 0, 0, 8'h44, 0));
    addv(1, 0, 0, 0, 8'h66, mk(S_RUN,   0, 0, 0, 8'h44, 0));
    addv(1, 0, 0, 0, 8'h66, mk(S_RUN,   0, 0, 0, 8'h44, 0));
    addv(0, 0, 0, 0, 8'h66, mk(S_RUN,   0, 0, 0, 8'h44, 0));
    addv(0, 0, 0, 0, 8'h66, mk(S_RUN,   0, 0, 0, 8'h44, 0));
    addv(0, 0, 0, 0, 8'h66, mk(S_RUN,   0, 1, 0, 8'h44, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      start_btn = tbl[i].s; stop_btn = tbl[i].p; clear_btn = tbl[i].c; load_btn = tbl[i].l;
      preset = tbl[i].pre;
      cyc(tbl[i].e);
    end
    start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0; load_btn = 1'b0;
    elv = 8'h44;

    // count 0 -> 3 in fast mode, then DONE behaviour
    tag = "count_to_3";
    do_clear();
    preset = 8'h10; target = 8'h03;
    run_to_done();
`ifndef TIMER_AUTO_RELOAD_EN
    tag = "done_hold";
    for (int i = 0; i < 1000; i++) begin
      start_btn = (i % 50 == 10);
      load_btn  = (i % 50 == 20);
      stop_btn  = (i % 50 == 30);
      cyc(mk(S_DONE, 1, 0, 0, elv, 0));
    end
    start_btn = 1'b0; load_btn = 1'b0; stop_btn = 1'b0;
`endif

    // preset FE, wrap through FF and 00, stop at 01
    tag = "wrap";
    do_clear();
    preset = 8'hFE;
    load_btn = 1'b1;
    elv = 8'hFE;
    cyc(mk(S_IDLE, 0, 0, 1, 8'hFE, 0));
    load_btn = 1'b0;
    cyc(mk(S_IDLE, 0, 0, 0, 8'hFE, 0));
    target = 8'h01;
    run_to_done();

    // target already equal at RUN entry
    tag = "target_at_entry";
    do_clear();
    target = 8'h00;
    start_btn = 1'b1;
    cyc(mk(S_RUN, 0, 0, 0, elv, 0));
    start_btn = 1'b0;
    cyc(mk(S_DONE, 1, 0, 0, elv, 0));

    // start + clear + stop together in RUN
    tag = "same_cycle";
    do_clear();
    target = 8'h50;
    start_btn = 1'b1;
    cyc(mk(S_RUN, 0, 0, 0, elv, 0));
    start_btn = 1'b0;
    cyc(mk(S_RUN, 0, 0, 0, elv, 0));
    cyc(mk(S_RUN, 0, 0, 0, elv, 0));
    start_btn = 1'b1; clear_btn = 1'b1; stop_btn = 1'b1;
    cyc(mk(S_IDLE, 0, 0, 0, elv, 1));
    start_btn = 1'b0; clear_btn = 1'b0; stop_btn = 1'b0;
    cyc(mk(S_IDLE, 0, 0, 0, elv, 0));

    // mode toggle mid-period, then reset in RUN
    tag = "mode_toggle";
    do_clear();
    start_btn = 1'b1;
    cyc(mk(S_RUN, 0, 0, 0, elv, 0));
    start_btn = 1'b0;
    cyc(mk(S_RUN, 0, 0, 0, elv, 0));
    cyc(mk(S_RUN, 0, 0, 0, elv, 0));
    mode = 1'b1;
    for (int c = 4; c <= 13; c++)
      cyc(mk(S_RUN, 0, logic'(c == 12), 0, elv, 0));
    tag = "reset_in_run";
    reset = 1'b1;
    elv = 8'h00;
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 1));
    reset = 1'b0;
    mode = 1'b0;
    for (int c = 0; c < 20; c++)
      cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
